// File: rtl/ex_mem_skid_stage_pkg.sv
// Shared pipeline definitions for the EX/MEM boundary and the other
// pipeline registers (ID/EX, MEM/WB).
//   CTRL_W / CTRL_WE / CTRL_SE / CTRL_LE : control vector width and bit positions
//   skid_state_t                         : occupancy of a 2-entry skid buffer
package ex_mem_skid_stage_pkg;

    localparam int unsigned CTRL_W  = 3;
    localparam int unsigned CTRL_WE = 0;
    localparam int unsigned CTRL_SE = 1;
    localparam int unsigned CTRL_LE = 2;

    // Encoding mirrors {skid_valid, main_valid}
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b11
    } skid_state_t;

endpackage

// File: rtl/ex_mem_skid_stage_skid.sv
// pipe_skid_buffer: generic 2-entry valid/ready skid buffer with flush.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid / in_ready   : upstream handshake (in_ready is a flop)
//   in_data  [W]          : upstream payload
//   flush                 : drop all held entries; next state EMPTY
//   out_valid / out_ready : downstream handshake (main entry)
//   out_data [W]          : main entry payload
module pipe_skid_buffer
    import ex_mem_skid_stage_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state_q, state_d;
    logic [W-1:0] main_q, skid_q;
    logic         ready_q;
    logic         accept, emit;
    logic         load_main_in, load_skid_in, move_skid;

    always_comb begin
        accept       = in_valid & ready_q;
        emit         = (state_q != SKID_EMPTY) & out_ready;
        state_d      = state_q;
        load_main_in = 1'b0;
        load_skid_in = 1'b0;
        move_skid    = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    state_d      = SKID_ONE;
                    load_main_in = 1'b1;
                end
            end
            SKID_ONE: begin
                if (accept && emit) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d      = SKID_FULL;
                    load_skid_in = 1'b1;
                end else if (emit) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (emit) begin
                    state_d   = SKID_ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        // Flush overrides everything, including a same-cycle accept
        if (flush) begin
            state_d      = SKID_EMPTY;
            load_main_in = 1'b0;
            load_skid_in = 1'b0;
            move_skid    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SKID_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            // Ready derived from next state so it never depends combinationally on out_ready
            ready_q <= (state_d != SKID_FULL);
            if (load_main_in) main_q <= in_data;
            else if (move_skid) main_q <= skid_q;
            if (load_skid_in) skid_q <= in_data;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = main_q;

endmodule

// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage: EX->MEM pipeline boundary with skid buffering.
//   clk, reset                         : clock, asynchronous active-high reset
//   ex_valid/ex_ready                  : handshake with EX (ex_ready registered)
//   result_in, reg_addr_in, mem_addr_in, ctrl_in : EX payload
//   flush                              : kill all held entries
//   mem_valid/mem_ready                : handshake with MEM
//   result_out, reg_addr_out, mem_addr_out, ctrl_out : main entry (ctrl 0 when invalid)
//   fwd_valid, fwd_reg_addr, fwd_data  : forwarding port to the hazard unit
//   stall_cycles                       : saturating count of held cycles
module ex_mem_skid_stage
    import ex_mem_skid_stage_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned REG_ADDR_W  = 4,
    parameter int unsigned MEM_ADDR_W  = 4,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [DATA_W-1:0]      result_in,
    input  logic [REG_ADDR_W-1:0]  reg_addr_in,
    input  logic [MEM_ADDR_W-1:0]  mem_addr_in,
    input  logic [CTRL_W-1:0]      ctrl_in,
    input  logic                   flush,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [DATA_W-1:0]      result_out,
    output logic [REG_ADDR_W-1:0]  reg_addr_out,
    output logic [MEM_ADDR_W-1:0]  mem_addr_out,
    output logic [CTRL_W-1:0]      ctrl_out,
    output logic                   fwd_valid,
    output logic [REG_ADDR_W-1:0]  fwd_reg_addr,
    output logic [DATA_W-1:0]      fwd_data,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int unsigned PAY_W = DATA_W + REG_ADDR_W + MEM_ADDR_W + CTRL_W;

    logic [PAY_W-1:0]  pay_in, pay_out;
    logic [CTRL_W-1:0] ctrl_raw;

    assign pay_in = {result_in, reg_addr_in, mem_addr_in, ctrl_in};

    pipe_skid_buffer #(.W(PAY_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (ex_valid),
        .in_ready  (ex_ready),
        .in_data   (pay_in),
        .flush     (flush),
        .out_valid (mem_valid),
        .out_ready (mem_ready),
        .out_data  (pay_out)
    );

    assign {result_out, reg_addr_out, mem_addr_out, ctrl_raw} = pay_out;

    // Payload may hold stale data after flush; masking ctrl prevents stray store/write
    assign ctrl_out     = mem_valid ? ctrl_raw : '0;
    assign fwd_valid    = mem_valid & ctrl_out[CTRL_WE];
    assign fwd_reg_addr = reg_addr_out;
    assign fwd_data     = result_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (mem_valid && !mem_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
module tb_ex_mem_skid_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [15:0] result_in = '0;
    logic [3:0]  reg_addr_in = '0;
    logic [3:0]  mem_addr_in = '0;
    logic [2:0]  ctrl_in = '0;
    logic        flush = 1'b0;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [15:0] result_out;
    logic [3:0]  reg_addr_out;
    logic [3:0]  mem_addr_out;
    logic [2:0]  ctrl_out;
    logic        fwd_valid;
    logic [3:0]  fwd_reg_addr;
    logic [15:0] fwd_data;
    logic [15:0] stall_cycles;

    // Second instance with a narrow counter to exercise saturation
    logic        s_ex_ready, s_mem_valid, s_fwd_valid;
    logic [15:0] s_result_out, s_fwd_data;
    logic [3:0]  s_reg_addr_out, s_mem_addr_out, s_fwd_reg_addr;
    logic [2:0]  s_ctrl_out;
    logic [3:0]  s_stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ex_mem_skid_stage #(.DATA_W(16), .REG_ADDR_W(4), .MEM_ADDR_W(4), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .result_in(result_in), .reg_addr_in(reg_addr_in), .mem_addr_in(mem_addr_in),
        .ctrl_in(ctrl_in), .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .result_out(result_out), .reg_addr_out(reg_addr_out), .mem_addr_out(mem_addr_out),
        .ctrl_out(ctrl_out), .fwd_valid(fwd_valid), .fwd_reg_addr(fwd_reg_addr),
        .fwd_data(fwd_data), .stall_cycles(stall_cycles)
    );

    ex_mem_skid_stage #(.DATA_W(16), .REG_ADDR_W(4), .MEM_ADDR_W(4), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(s_ex_ready),
        .result_in(result_in), .reg_addr_in(reg_addr_in), .mem_addr_in(mem_addr_in),
        .ctrl_in(ctrl_in), .flush(flush), .mem_valid(s_mem_valid), .mem_ready(mem_ready),
        .result_out(s_result_out), .reg_addr_out(s_reg_addr_out), .mem_addr_out(s_mem_addr_out),
        .ctrl_out(s_ctrl_out), .fwd_valid(s_fwd_valid), .fwd_reg_addr(s_fwd_reg_addr),
        .fwd_data(s_fwd_data), .stall_cycles(s_stall_cycles)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] ra,
                         input logic [3:0] ma, input logic [2:0] c);
        ex_valid = v; result_in = r; reg_addr_in = ra; mem_addr_in = ma; ctrl_in = c;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
        vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ex_ready got %b want 1", ex_ready); end
        vectors++; if (result_out !== 16'h0) begin miscompares++; $display("FAIL reset_result got %h want 0000", result_out); end
        vectors++; if (ctrl_out !== 3'b000) begin miscompares++; $display("FAIL reset_ctrl got %b want 000", ctrl_out); end
        vectors++; if (stall_cycles !== 16'h0) begin miscompares++; $display("FAIL reset_stall got %0d want 0", stall_cycles); end
        vectors++; if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fwd_valid got %b want 0", fwd_valid); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_stream();
        mem_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 16'(i), 4'(i), 4'(i + 3), 3'b001);
            step();
            vectors++; if (mem_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d] got %b want 1", i, mem_valid); end
            vectors++; if (result_out !== 16'(i)) begin miscompares++; $display("FAIL stream_result[%0d] got %h want %h", i, result_out, 16'(i)); end
            vectors++; if (reg_addr_out !== 4'(i) || mem_addr_out !== 4'(i + 3)) begin miscompares++; $display("FAIL stream_addr[%0d] got %h/%h want %h/%h", i, reg_addr_out, mem_addr_out, 4'(i), 4'(i + 3)); end
            vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready[%0d] got %b want 1", i, ex_ready); end
        end
        drive(1'b0, 16'h0, 4'h0, 4'h0, 3'b111);
        step();
        vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL stream_bubble_valid got %b want 0", mem_valid); end
        vectors++; if (ctrl_out !== 3'b000) begin miscompares++; $display("FAIL stream_bubble_ctrl got %b want 000", ctrl_out); end
        vectors++; if (stall_cycles !== 16'd0) begin miscompares++; $display("FAIL stream_stall got %0d want 0", stall_cycles); end
    endtask

    task automatic test_backpressure();
        mem_ready = 1'b0;
        drive(1'b1, 16'h1111, 4'h1, 4'h1, 3'b001);
        step();
        vectors++; if (mem_valid !== 1'b1 || result_out !== 16'h1111) begin miscompares++; $display("FAIL bp_A got %b/%h want 1/1111", mem_valid, result_out); end
        vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_one got %b want 1", ex_ready); end
        drive(1'b1, 16'h2222, 4'h2, 4'h2, 3'b001);
        step();
        vectors++; if (ex_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_full got %b want 0", ex_ready); end
        vectors++; if (result_out !== 16'h1111) begin miscompares++; $display("FAIL bp_hold_A got %h want 1111", result_out); end
        vectors++; if (stall_cycles !== 16'd1) begin miscompares++; $display("FAIL bp_stall1 got %0d want 1", stall_cycles); end
        // Offered while FULL: must not be taken
        drive(1'b1, 16'hDEAD, 4'hD, 4'hD, 3'b001);
        step();
        drive(1'b0, 16'h0, 4'h0, 4'h0, 3'b000);
        step();
        vectors++; if (stall_cycles !== 16'd3) begin miscompares++; $display("FAIL bp_stall3 got %0d want 3", stall_cycles); end
        vectors++; if (ex_ready !== 1'b0 || result_out !== 16'h1111) begin miscompares++; $display("FAIL bp_still_full got %b/%h want 0/1111", ex_ready, result_out); end
        mem_ready = 1'b1;
        step();
        vectors++; if (mem_valid !== 1'b1 || result_out !== 16'h2222) begin miscompares++; $display("FAIL bp_B got %b/%h want 1/2222", mem_valid, result_out); end
        vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_release got %b want 1", ex_ready); end
        step();
        vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained got %b want 0", mem_valid); end
        vectors++; if (stall_cycles !== 16'd3) begin miscompares++; $display("FAIL bp_stall_final got %0d want 3", stall_cycles); end
    endtask

    task automatic test_flush();
        mem_ready = 1'b0;
        drive(1'b1, 16'h4444, 4'h4, 4'h4, 3'b011);
        step();
        drive(1'b1, 16'h5555, 4'h5, 4'h5, 3'b011);
        step();
        vectors++; if (ex_ready !== 1'b0) begin miscompares++; $display("FAIL flush_prefull got %b want 0", ex_ready); end
        drive(1'b1, 16'h3333, 4'h3, 4'h3, 3'b011);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 4'h0, 3'b000);
        vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b want 0", mem_valid); end
        vectors++; if (ctrl_out !== 3'b000) begin miscompares++; $display("FAIL flush_ctrl got %b want 000", ctrl_out); end
        vectors++; if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL flush_fwd got %b want 0", fwd_valid); end
        vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b want 1", ex_ready); end
        vectors++; if (stall_cycles !== 16'd5) begin miscompares++; $display("FAIL flush_stall got %0d want 5", stall_cycles); end
        mem_ready = 1'b1;
        step();
        vectors++; if (mem_valid !== 1'b0 || result_out === 16'h3333) begin miscompares++; $display("FAIL flush_C_dropped got %b/%h want 0/not-3333", mem_valid, result_out); end
    endtask

    task automatic test_forwarding();
        mem_ready = 1'b1;
        drive(1'b1, 16'hBEEF, 4'h5, 4'hA, 3'b001);
        step();
        vectors++; if (fwd_valid !== 1'b1) begin miscompares++; $display("FAIL fwd_valid_we got %b want 1", fwd_valid); end
        vectors++; if (fwd_reg_addr !== 4'h5) begin miscompares++; $display("FAIL fwd_reg_addr got %h want 5", fwd_reg_addr); end
        vectors++; if (fwd_data !== 16'hBEEF) begin miscompares++; $display("FAIL fwd_data got %h want beef", fwd_data); end
        vectors++; if (mem_addr_out !== 4'hA || ctrl_out !== 3'b001) begin miscompares++; $display("FAIL fwd_addr_ctrl got %h/%b want a/001", mem_addr_out, ctrl_out); end
        drive(1'b1, 16'h1234, 4'h6, 4'h3, 3'b010);
        step();
        vectors++; if (fwd_valid !== 1'b0) begin miscompares++; $display("FAIL fwd_store got %b want 0", fwd_valid); end
        vectors++; if (ctrl_out !== 3'b010) begin miscompares++; $display("FAIL store_ctrl got %b want 010", ctrl_out); end
        drive(1'b1, 16'h0042, 4'h7, 4'h9, 3'b100);
        step();
        vectors++; if (ctrl_out !== 3'b100 || fwd_valid !== 1'b0) begin miscompares++; $display("FAIL load_ctrl got %b/%b want 100/0", ctrl_out, fwd_valid); end
        drive(1'b0, 16'h0, 4'h0, 4'h0, 3'b000);
        step();
    endtask

    task automatic test_async_reset();
        mem_ready = 1'b0;
        drive(1'b1, 16'h6666, 4'h6, 4'h6, 3'b001);
        step();
        drive(1'b1, 16'h7777, 4'h7, 4'h7, 3'b001);
        step();
        drive(1'b0, 16'h0, 4'h0, 4'h0, 3'b000);
        vectors++; if (ex_ready !== 1'b0 || stall_cycles !== 16'd6) begin miscompares++; $display("FAIL arst_prefull got %b/%0d want 0/6", ex_ready, stall_cycles); end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (mem_valid !== 1'b0 || result_out !== 16'h0) begin miscompares++; $display("FAIL arst_outputs got %b/%h want 0/0000", mem_valid, result_out); end
        vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL arst_ready got %b want 1", ex_ready); end
        vectors++; if (stall_cycles !== 16'd0 || ctrl_out !== 3'b000) begin miscompares++; $display("FAIL arst_stall_ctrl got %0d/%b want 0/000", stall_cycles, ctrl_out); end
        #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        drive(1'b1, 16'h9999, 4'h9, 4'h9, 3'b001);
        step();
        vectors++; if (mem_valid !== 1'b1 || result_out !== 16'h9999) begin miscompares++; $display("FAIL arst_resume got %b/%h want 1/9999", mem_valid, result_out); end
        drive(1'b0, 16'h0, 4'h0, 4'h0, 3'b000);
        step();
    endtask

    task automatic test_saturation();
        #2;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        mem_ready = 1'b0;
        drive(1'b1, 16'h7777, 4'h7, 4'h7, 3'b001);
        step();
        drive(1'b0, 16'h0, 4'h0, 4'h0, 3'b000);
        for (int k = 1; k <= 20; k++) begin
            step();
            vectors++; if (s_stall_cycles !== 4'((k > 15) ? 15 : k)) begin miscompares++; $display("FAIL sat_count[%0d] got %h want %h", k, s_stall_cycles, 4'((k > 15) ? 15 : k)); end
        end
        vectors++; if (stall_cycles !== 16'd20) begin miscompares++; $display("FAIL wide_count got %0d want 20", stall_cycles); end
        mem_ready = 1'b1;
        step();
        vectors++; if (s_mem_valid !== 1'b0 || s_stall_cycles !== 4'hF) begin miscompares++; $display("FAIL sat_drain got %b/%h want 0/f", s_mem_valid, s_stall_cycles); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_forwarding();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
